// File: rtl/input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner_if
// Brief    : Raw-input / conditioned-output bundle for input_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
interface input_conditioner_if #(
    parameter int GLITCH_W = 8
);
    logic                d_i;
    logic                glitch_clr_i;
    logic                level_o;
    logic                rise_o;
    logic                fall_o;
    logic                glitch_o;
    logic [GLITCH_W-1:0] glitch_cnt_o;

    modport master (
        output d_i,
        output glitch_clr_i,
        input  level_o,
        input  rise_o,
        input  fall_o,
        input  glitch_o,
        input  glitch_cnt_o
    );

    modport slave (
        input  d_i,
        input  glitch_clr_i,
        output level_o,
        output rise_o,
        output fall_o,
        output glitch_o,
        output glitch_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Brief    : Synchronise, debounce and edge-detect a raw asynchronous input.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input wire clk,
    input wire reset,
    input_conditioner_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]       C_ONE  = CW'(1);
    localparam logic [CW-1:0]       C_TERM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] C_GMAX = '1;
    localparam logic [GLITCH_W-1:0] C_G1   = GLITCH_W'(1);

    typedef enum logic [1:0] {
        ST_LO      = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_HI      = 2'd2,
        ST_PEND_LO = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_glitch;
    logic [GLITCH_W-1:0]    r_gcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.d_i};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // cnt counts synced samples already seen at the new value; the pending
    // state itself accounts for the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_LO;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
            case (r_state)
                ST_LO: begin
                    if (w_s) begin
                        r_state <= ST_PEND_HI;
                        r_cnt   <= C_ONE;
                    end
                end
                ST_PEND_HI: begin
                    if (!w_s) begin
                        r_state  <= ST_LO;
                        r_glitch <= 1'b1;
                        r_cnt    <= '0;
                    end else if (r_cnt == C_TERM) begin
                        r_state <= ST_HI;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                ST_HI: begin
                    if (!w_s) begin
                        r_state <= ST_PEND_LO;
                        r_cnt   <= C_ONE;
                    end
                end
                ST_PEND_LO: begin
                    if (w_s) begin
                        r_state  <= ST_HI;
                        r_glitch <= 1'b1;
                        r_cnt    <= '0;
                    end else if (r_cnt == C_TERM) begin
                        r_state <= ST_LO;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: begin
                    r_state <= ST_LO;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    // Counts the visible glitch_o pulse; a clear in that same cycle still keeps it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gcnt <= '0;
        end else if (bus.glitch_clr_i) begin
            r_gcnt <= r_glitch ? C_G1 : '0;
        end else if (r_glitch && (r_gcnt != C_GMAX)) begin
            r_gcnt <= r_gcnt + C_G1;
        end
    end

    assign bus.level_o      = r_level;
    assign bus.rise_o       = r_rise;
    assign bus.fall_o       = r_fall;
    assign bus.glitch_o     = r_glitch;
    assign bus.glitch_cnt_o = r_gcnt;

endmodule
`default_nettype wire
